mem_req_rr_arbiter: RTL and testbench
=====================================

// Module: mem_req_rr_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the AXI-Lite master controller's mem_req_*/axi_cpld_* interface.
//  Shares one PCIe-to-AXI memory request port between requester 0 (host RX TLP path) and requester 1 (internal agent).
//  Records the requester ID of every accepted read in an in-order route FIFO.
//  Steers each returning completion to the requester that issued the read.
// PARAMETERS
//  OUTSTANDING_READS  5  route FIFO depth; max accepted reads awaiting completion (1..15)
// PORTS
//  m_axi_aclk            in   1   clock
//  m_axi_areset          in   1   asynchronous active-high reset
//  reqN_valid            in   1   requester N (N=0,1) request valid; held stable until reqN_ready
//  reqN_ready            out  1   requester N request accepted this cycle
//  reqN_bar_hit          in   3   requester N BAR index
//  reqN_pcie_address     in   32  requester N PCIe address
//  reqN_byte_enable      in   8   requester N byte enables
//  reqN_write_readn      in   1   requester N 1=write 0=read
//  reqN_phys_func        in   1   requester N function number
//  reqN_write_data       in   64  requester N write data
//  cpldN_valid           out  1   completion valid to requester N
//  cpldN_ready           in   1   requester N accepts completion
//  cpldN_data            out  64  completion data (axi_cpld_data fanned out to both)
//  mem_req_valid         out  1   request valid to controller
//  mem_req_ready         in   1   controller accepts request
//  mem_req_bar_hit/pcie_address/byte_enable/write_readn/phys_func/write_data  out  3/32/8/1/1/64  muxed fields of granted requester
//  axi_cpld_valid        in   1   completion from controller
//  axi_cpld_ready        out  1   completion accepted
//  axi_cpld_data         in   64  completion data
//  rd_outstanding        out  4   route FIFO occupancy
//  cpl_orphan            out  1   sticky: completion arrived with route FIFO empty
// BEHAVIOUR
//  Reset: FSM=IDLE, grant=0, last_grant=1 (req0 wins first), FIFO empty, rd_outstanding=0, cpl_orphan=0.
//  Reset: all valid/ready outputs 0. Reset mid-transfer drops in-flight grant and routes; requesters re-present.
//  FSM IDLE: if any reqN_valid, register grant and go to GRANT.
//    Both valid: pick requester != last_grant. One valid: pick that one. mem_req_valid=0 in IDLE.
//  FSM GRANT: mem_req_* = granted requester's fields (combinational mux on registered grant).
//    mem_req_valid = reqG_valid & ~(read & FIFO full). reqG_ready = mem_req_ready & mem_req_valid. Other ready=0.
//  Handshake (mem_req_valid & mem_req_ready): last_grant<=grant, FSM->IDLE.
//    If read: push grant into route FIFO. Handshake cost: 1 idle cycle between grants.
//  Latency: reqN_valid rise -> mem_req_valid one cycle later (FIFO not full).
//  FIFO full (rd_outstanding==OUTSTANDING_READS): granted read stalls in GRANT; granted write proceeds.
//  Completion: head=FIFO head ID. cpld[head]_valid = axi_cpld_valid & ~empty. Other cpld valid=0.
//    axi_cpld_ready = cpld[head]_ready & ~empty. Pop on axi_cpld_valid & axi_cpld_ready.
//  Empty FIFO with axi_cpld_valid: axi_cpld_ready=0, both cpld valid=0, cpl_orphan<=1 (cleared only by reset).
//  Simultaneous push and pop: occupancy unchanged; pop of a full FIFO permits the same-cycle push.
//  Pointers wrap modulo OUTSTANDING_READS; rd_outstanding = push count - pop count, never exceeds depth.
// TESTING
//  1. Both valid, reads, ready=1 always: grants alternate 0,1,0,1; first grant req0; FIFO order 0,1,0,1.
//  2. req0 write held, mem_req_ready=0 for 10 cycles: mem_req_valid high, fields stable, req0_ready only on cycle 11.
//  3. Six req1 reads, no completions: rd_outstanding reaches 5. Sixth read stalls with mem_req_valid=0.
//     Then a req0 write behind it is still blocked; after one completion, the sixth read issues.
//  4. Reads from 1 then 0, completions 0xA,0xB: cpld1_data=0xA then cpld0_data=0xB. cpld1_ready=0 stalls axi_cpld_ready.
//  5. axi_cpld_valid with FIFO empty: axi_cpld_ready=0, cpl_orphan=1 next cycle, stays 1.
//  6. Assert m_axi_areset while in GRANT with 3 reads outstanding: all outputs 0 immediately; rd_outstanding=0.

Source files
------------

// File: rtl/mem_req_rr_arbiter.sv
// Round-robin share of one mem_req port between two requesters, with an in-order
// route FIFO that steers each read completion back to the requester that issued it.
module mem_req_rr_arbiter #(
    parameter int OUTSTANDING_READS = 5
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_areset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_bar_hit,
    input  logic [31:0] req0_pcie_address,
    input  logic [7:0]  req0_byte_enable,
    input  logic        req0_write_readn,
    input  logic        req0_phys_func,
    input  logic [63:0] req0_write_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_bar_hit,
    input  logic [31:0] req1_pcie_address,
    input  logic [7:0]  req1_byte_enable,
    input  logic        req1_write_readn,
    input  logic        req1_phys_func,
    input  logic [63:0] req1_write_data,
    output logic        cpld0_valid,
    input  logic        cpld0_ready,
    output logic [63:0] cpld0_data,
    output logic        cpld1_valid,
    input  logic        cpld1_ready,
    output logic [63:0] cpld1_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [2:0]  mem_req_bar_hit,
    output logic [31:0] mem_req_pcie_address,
    output logic [7:0]  mem_req_byte_enable,
    output logic        mem_req_write_readn,
    output logic        mem_req_phys_func,
    output logic [63:0] mem_req_write_data,
    input  logic        axi_cpld_valid,
    output logic        axi_cpld_ready,
    input  logic [63:0] axi_cpld_data,
    output logic [3:0]  rd_outstanding,
    output logic        cpl_orphan
);
    localparam logic [3:0] DEPTH = 4'(OUTSTANDING_READS);
    localparam logic [3:0] LAST  = 4'(OUTSTANDING_READS - 1);

    typedef struct packed {
        logic [2:0]  bar_hit;
        logic [31:0] pcie_address;
        logic [7:0]  byte_enable;
        logic        write_readn;
        logic        phys_func;
        logic [63:0] write_data;
    } mem_req_t;

    typedef enum logic {IDLE, GRANT} state_t;

    mem_req_t [1:0] req;
    mem_req_t       sel;
    logic [1:0]     req_valid;
    state_t         state_q, state_d;
    logic           grant_q, grant_d, last_grant_q;
    logic [15:0]    route_q;
    logic [3:0]     wr_ptr, rd_ptr, count;
    logic           orphan_q;
    logic           empty, full, head, head_ready, is_read, pop, push, hs;

    assign req[0] = {req0_bar_hit, req0_pcie_address, req0_byte_enable,
                     req0_write_readn, req0_phys_func, req0_write_data};
    assign req[1] = {req1_bar_hit, req1_pcie_address, req1_byte_enable,
                     req1_write_readn, req1_phys_func, req1_write_data};
    assign req_valid = {req1_valid, req0_valid};

    assign sel                  = req[grant_q];
    assign is_read              = ~sel.write_readn;
    assign mem_req_bar_hit      = sel.bar_hit;
    assign mem_req_pcie_address = sel.pcie_address;
    assign mem_req_byte_enable  = sel.byte_enable;
    assign mem_req_write_readn  = sel.write_readn;
    assign mem_req_phys_func    = sel.phys_func;
    assign mem_req_write_data   = sel.write_data;

    // Completion steering from the FIFO head
    assign empty          = (count == 4'd0);
    assign full           = (count == DEPTH);
    assign head           = route_q[rd_ptr];
    assign head_ready     = head ? cpld1_ready : cpld0_ready;
    assign cpld0_valid    = axi_cpld_valid & ~empty & ~head;
    assign cpld1_valid    = axi_cpld_valid & ~empty & head;
    assign axi_cpld_ready = head_ready & ~empty;
    assign cpld0_data     = axi_cpld_data;
    assign cpld1_data     = axi_cpld_data;
    assign pop            = axi_cpld_valid & axi_cpld_ready;
    assign rd_outstanding = count;
    assign cpl_orphan     = orphan_q;

    assign hs   = mem_req_valid & mem_req_ready;
    assign push = hs & is_read;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_req_valid = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // Both asking: the one not served last time wins
                    grant_d = (&req_valid) ? ~last_grant_q : req_valid[1];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A same-cycle pop frees the slot a full FIFO would otherwise deny
                mem_req_valid = req_valid[grant_q] & ~(is_read & full & ~pop);
                req0_ready    = mem_req_ready & mem_req_valid & ~grant_q;
                req1_ready    = mem_req_ready & mem_req_valid & grant_q;
                if (mem_req_valid & mem_req_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (hs)
                last_grant_q <= grant_q;
        end
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            route_q  <= '0;
            wr_ptr   <= 4'd0;
            rd_ptr   <= 4'd0;
            count    <= 4'd0;
            orphan_q <= 1'b0;
        end else begin
            if (push) begin
                route_q[wr_ptr] <= grant_q;
                wr_ptr          <= (wr_ptr == LAST) ? 4'd0 : wr_ptr + 4'd1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? 4'd0 : rd_ptr + 4'd1;
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (axi_cpld_valid & empty)
                orphan_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_req_rr_arbiter.sv
// Directed bench for mem_req_rr_arbiter: arbitration order, backpressure,
// route FIFO full/ordering, orphan completions and asynchronous reset.
module tb_mem_req_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_write_readn, req0_phys_func;
    logic [2:0]  req0_bar_hit;
    logic [31:0] req0_pcie_address;
    logic [7:0]  req0_byte_enable;
    logic [63:0] req0_write_data;
    logic        req1_valid, req1_ready, req1_write_readn, req1_phys_func;
    logic [2:0]  req1_bar_hit;
    logic [31:0] req1_pcie_address;
    logic [7:0]  req1_byte_enable;
    logic [63:0] req1_write_data;
    logic        cpld0_valid, cpld0_ready, cpld1_valid, cpld1_ready;
    logic [63:0] cpld0_data, cpld1_data;
    logic        mem_req_valid, mem_req_ready, mem_req_write_readn, mem_req_phys_func;
    logic [2:0]  mem_req_bar_hit;
    logic [31:0] mem_req_pcie_address;
    logic [7:0]  mem_req_byte_enable;
    logic [63:0] mem_req_write_data;
    logic        axi_cpld_valid, axi_cpld_ready;
    logic [63:0] axi_cpld_data;
    logic [3:0]  rd_outstanding;
    logic        cpl_orphan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_req_rr_arbiter #(.OUTSTANDING_READS(5)) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bar_hit(req0_bar_hit),
        .req0_pcie_address(req0_pcie_address), .req0_byte_enable(req0_byte_enable),
        .req0_write_readn(req0_write_readn), .req0_phys_func(req0_phys_func),
        .req0_write_data(req0_write_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bar_hit(req1_bar_hit),
        .req1_pcie_address(req1_pcie_address), .req1_byte_enable(req1_byte_enable),
        .req1_write_readn(req1_write_readn), .req1_phys_func(req1_phys_func),
        .req1_write_data(req1_write_data),
        .cpld0_valid(cpld0_valid), .cpld0_ready(cpld0_ready), .cpld0_data(cpld0_data),
        .cpld1_valid(cpld1_valid), .cpld1_ready(cpld1_ready), .cpld1_data(cpld1_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_bar_hit(mem_req_bar_hit), .mem_req_pcie_address(mem_req_pcie_address),
        .mem_req_byte_enable(mem_req_byte_enable), .mem_req_write_readn(mem_req_write_readn),
        .mem_req_phys_func(mem_req_phys_func), .mem_req_write_data(mem_req_write_data),
        .axi_cpld_valid(axi_cpld_valid), .axi_cpld_ready(axi_cpld_ready),
        .axi_cpld_data(axi_cpld_data),
        .rd_outstanding(rd_outstanding), .cpl_orphan(cpl_orphan)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 0; req0_write_readn = 0; req0_phys_func = 0; req0_bar_hit = 3'd1;
        req0_pcie_address = 32'h1000_0000; req0_byte_enable = 8'hFF; req0_write_data = 64'h0;
        req1_valid = 0; req1_write_readn = 0; req1_phys_func = 1; req1_bar_hit = 3'd2;
        req1_pcie_address = 32'h2000_0000; req1_byte_enable = 8'h0F; req1_write_data = 64'h0;
        cpld0_ready = 1; cpld1_ready = 1; mem_req_ready = 1;
        axi_cpld_valid = 0; axi_cpld_data = 64'h0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_req_valid got %b exp 0", mem_req_valid); end
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rst_req_ready got %b exp 00", {req0_ready, req1_ready}); end
        total++; if ({cpld0_valid, cpld1_valid, axi_cpld_ready} !== 3'b000) begin bad++; $display("FAIL rst_cpl got %b exp 000", {cpld0_valid, cpld1_valid, axi_cpld_ready}); end
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL rst_outstanding got %0d exp 0", rd_outstanding); end
        total++; if (cpl_orphan !== 1'b0) begin bad++; $display("FAIL rst_orphan got %b exp 0", cpl_orphan); end
    endtask

    task automatic test_alternate();
        logic exp_id;
        do_reset();
        req0_valid = 1; req1_valid = 1;
        #2;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL alt_idle_valid got %b exp 0", mem_req_valid); end
        for (int i = 0; i < 4; i++) begin
            exp_id = 1'(i % 2);
            tick();
            total++; if ({mem_req_valid, req1_ready, req0_ready} !== {1'b1, exp_id, ~exp_id}) begin
                bad++; $display("FAIL alt_grant%0d got v/r1/r0=%b exp %b", i, {mem_req_valid, req1_ready, req0_ready}, {1'b1, exp_id, ~exp_id}); end
            total++; if (mem_req_pcie_address !== (exp_id ? 32'h2000_0000 : 32'h1000_0000)) begin
                bad++; $display("FAIL alt_addr%0d got %h", i, mem_req_pcie_address); end
            tick();
            total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL alt_gap%0d got %b exp 0", i, mem_req_valid); end
        end
        req0_valid = 0; req1_valid = 0;
        #2;
        total++; if (rd_outstanding !== 4'd4) begin bad++; $display("FAIL alt_outstanding got %0d exp 4", rd_outstanding); end
        for (int i = 0; i < 4; i++) begin
            exp_id = 1'(i % 2);
            axi_cpld_valid = 1; axi_cpld_data = 64'(100 + i);
            #2;
            total++; if ({cpld1_valid, cpld0_valid, axi_cpld_ready} !== {exp_id, ~exp_id, 1'b1}) begin
                bad++; $display("FAIL alt_route%0d got c1/c0/rdy=%b exp %b", i, {cpld1_valid, cpld0_valid, axi_cpld_ready}, {exp_id, ~exp_id, 1'b1}); end
            tick();
        end
        axi_cpld_valid = 0;
        #2;
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL alt_drain got %0d exp 0", rd_outstanding); end
        total++; if (cpl_orphan !== 1'b0) begin bad++; $display("FAIL alt_orphan got %b exp 0", cpl_orphan); end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_req_ready = 0;
        req0_valid = 1; req0_write_readn = 1; req0_pcie_address = 32'hCAFE_0040;
        req0_write_data = 64'h1122_3344_5566_7788;
        for (int c = 1; c <= 10; c++) begin
            tick();
            total++; if ({mem_req_valid, req0_ready, mem_req_pcie_address, mem_req_write_data} !==
                         {1'b1, 1'b0, 32'hCAFE_0040, 64'h1122_3344_5566_7788}) begin
                bad++; $display("FAIL bp_hold%0d got v=%b r=%b a=%h d=%h", c, mem_req_valid, req0_ready, mem_req_pcie_address, mem_req_write_data); end
        end
        tick();
        mem_req_ready = 1;
        #2;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_accept got %b exp 1", req0_ready); end
        tick();
        req0_valid = 0;
        #2;
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL bp_write_no_route got %0d exp 0", rd_outstanding); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        req1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL full_rd%0d got %b exp 1", i, req1_ready); end
            tick();
        end
        total++; if (rd_outstanding !== 4'd5) begin bad++; $display("FAIL full_count got %0d exp 5", rd_outstanding); end
        tick();
        total++; if ({mem_req_valid, req1_ready} !== 2'b00) begin bad++; $display("FAIL full_stall got %b exp 00", {mem_req_valid, req1_ready}); end
        req0_valid = 1; req0_write_readn = 1;
        tick();
        tick();
        total++; if ({mem_req_valid, req0_ready, req1_ready} !== 3'b000) begin
            bad++; $display("FAIL full_block_wr got %b exp 000", {mem_req_valid, req0_ready, req1_ready}); end
        axi_cpld_valid = 1; axi_cpld_data = 64'h55;
        #2;
        total++; if ({cpld1_valid, mem_req_valid, req1_ready} !== 3'b111) begin
            bad++; $display("FAIL full_release got %b exp 111", {cpld1_valid, mem_req_valid, req1_ready}); end
        tick();
        axi_cpld_valid = 0; req1_valid = 0;
        #2;
        total++; if (rd_outstanding !== 4'd5) begin bad++; $display("FAIL full_pushpop got %0d exp 5", rd_outstanding); end
        tick();
        total++; if ({mem_req_valid, req0_ready} !== 2'b11) begin bad++; $display("FAIL full_wr_pass got %b exp 11", {mem_req_valid, req0_ready}); end
        tick();
        req0_valid = 0;
    endtask

    task automatic test_routing();
        do_reset();
        req1_valid = 1;
        tick();
        tick();
        req1_valid = 0; req0_valid = 1;
        tick();
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL route_rd0 got %b exp 1", req0_ready); end
        tick();
        req0_valid = 0;
        #2;
        total++; if (rd_outstanding !== 4'd2) begin bad++; $display("FAIL route_count got %0d exp 2", rd_outstanding); end
        cpld1_ready = 0; axi_cpld_valid = 1; axi_cpld_data = 64'hA;
        #2;
        total++; if ({cpld1_valid, cpld0_valid, axi_cpld_ready} !== 3'b100) begin
            bad++; $display("FAIL route_stall got %b exp 100", {cpld1_valid, cpld0_valid, axi_cpld_ready}); end
        tick();
        total++; if (rd_outstanding !== 4'd2) begin bad++; $display("FAIL route_nopop got %0d exp 2", rd_outstanding); end
        cpld1_ready = 1;
        #2;
        total++; if ({axi_cpld_ready, cpld1_data} !== {1'b1, 64'hA}) begin
            bad++; $display("FAIL route_first got rdy=%b d=%h exp 1/a", axi_cpld_ready, cpld1_data); end
        tick();
        axi_cpld_data = 64'hB;
        #2;
        total++; if ({cpld1_valid, cpld0_valid, cpld0_data} !== {2'b01, 64'hB}) begin
            bad++; $display("FAIL route_second got c1/c0=%b d=%h exp 01/b", {cpld1_valid, cpld0_valid}, cpld0_data); end
        tick();
        axi_cpld_valid = 0;
        #2;
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL route_drain got %0d exp 0", rd_outstanding); end
    endtask

    task automatic test_orphan();
        do_reset();
        axi_cpld_valid = 1; axi_cpld_data = 64'hDEAD;
        #2;
        total++; if ({axi_cpld_ready, cpld0_valid, cpld1_valid, cpl_orphan} !== 4'b0000) begin
            bad++; $display("FAIL orphan_pre got %b exp 0000", {axi_cpld_ready, cpld0_valid, cpld1_valid, cpl_orphan}); end
        tick();
        axi_cpld_valid = 0;
        #2;
        total++; if (cpl_orphan !== 1'b1) begin bad++; $display("FAIL orphan_set got %b exp 1", cpl_orphan); end
        tick();
        tick();
        total++; if (cpl_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky got %b exp 1", cpl_orphan); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req0_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        mem_req_ready = 0;
        tick();
        axi_cpld_valid = 1;
        #1;
        total++; if ({rd_outstanding, mem_req_valid, cpld0_valid} !== {4'd3, 2'b11}) begin
            bad++; $display("FAIL mid_pre got cnt=%0d v=%b c0=%b exp 3/1/1", rd_outstanding, mem_req_valid, cpld0_valid); end
        rst = 1;
        #1;
        total++; if ({mem_req_valid, req0_ready, req1_ready, cpld0_valid, cpld1_valid, axi_cpld_ready} !== 6'b0) begin
            bad++; $display("FAIL mid_outputs got %b exp 000000", {mem_req_valid, req0_ready, req1_ready, cpld0_valid, cpld1_valid, axi_cpld_ready}); end
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL mid_outstanding got %0d exp 0", rd_outstanding); end
        axi_cpld_valid = 0; req0_valid = 0;
        tick();
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_backpressure();
        test_fifo_full();
        test_routing();
        test_orphan();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
